// File: rtl/parity_word_checker_if.sv
// rtl/parity_word_checker_if.sv - serial frame input and checked-frame output bundle
interface parity_word_checker_if;
  logic        SI;
  logic        SEN;
  logic        CLR;
  logic        DRDY;
  logic [10:0] DO;
  logic        DV;
  logic        PERR;
  logic        OVF;
  logic [7:0]  ECNT;

  modport slave (
    input  SI, SEN, CLR, DRDY,
    output DO, DV, PERR, OVF, ECNT
  );

  modport master (
    output SI, SEN, CLR, DRDY,
    input  DO, DV, PERR, OVF, ECNT
  );
endinterface

// File: rtl/parity_word_checker.sv
// rtl/parity_word_checker.sv - 11-bit serial frame assembler with parity check and one-entry output hold
module parity_word_checker #(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                   CK,
  input  logic                   RSTN,
  parity_word_checker_if.slave   bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] do_q, do_d;
  logic        perr_q, perr_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  ecnt_q, ecnt_d;

  logic        shift_en;
  logic        frame_done;
  logic [10:0] frame_word;
  logic        frame_perr;
  logic        drain;
  logic        accept;
  logic        drop;

  // CLR discards any bit offered in the same cycle, so it also blocks completion.
  assign shift_en   = bus.SEN & ~bus.CLR;
  assign frame_done = shift_en & (cnt_q == 4'd10);
  assign frame_word = {sr_q[9:0], bus.SI};
  assign frame_perr = (^frame_word) ^ PARITY_ODD;

  assign drain  = (state_q == ST_FULL) & bus.DRDY;
  assign accept = frame_done & ((state_q == ST_EMPTY) | bus.DRDY);
  assign drop   = frame_done & (state_q == ST_FULL) & ~bus.DRDY;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (bus.CLR) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (bus.SEN) begin
      sr_d  = frame_word;
      cnt_d = (cnt_q == 4'd10) ? 4'd0 : cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    do_d    = do_q;
    perr_d  = perr_q;
    ecnt_d  = ecnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (drain && !frame_done) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (accept) begin
      do_d   = frame_word;
      perr_d = frame_perr;
      if (frame_perr && (ecnt_q != 8'hFF)) begin
        ecnt_d = ecnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (bus.CLR) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_EMPTY;
      sr_q    <= '0;
      cnt_q   <= '0;
      do_q    <= '0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      do_q    <= do_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign bus.DO   = do_q;
  assign bus.DV   = (state_q == ST_FULL);
  assign bus.PERR = perr_q;
  assign bus.OVF  = ovf_q;
  assign bus.ECNT = ecnt_q;

endmodule

// File: tb/tb_parity_word_checker.sv
// tb/tb_parity_word_checker.sv - directed table and sequence bench, even and odd parity instances
module tb_parity_word_checker;

  logic ck;
  logic rstn;
  logic si, sen, clr, drdy;

  int n_cmp;
  int n_fail;

  parity_word_checker_if ife ();
  parity_word_checker_if ifo ();

  assign ife.SI   = si;
  assign ife.SEN  = sen;
  assign ife.CLR  = clr;
  assign ife.DRDY = drdy;
  assign ifo.SI   = si;
  assign ifo.SEN  = sen;
  assign ifo.CLR  = clr;
  assign ifo.DRDY = drdy;

  parity_word_checker #(.PARITY_ODD(1'b0)) dut_even (
    .CK   (ck),
    .RSTN (rstn),
    .bus  (ife)
  );

  parity_word_checker #(.PARITY_ODD(1'b1)) dut_odd (
    .CK   (ck),
    .RSTN (rstn),
    .bus  (ifo)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic [10:0] word;
    logic        perr_even;
    logic        perr_odd;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    si   = 1'b0;
    sen  = 1'b0;
    clr  = 1'b0;
    drdy = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic shift_word(input logic [10:0] w);
    for (int i = 10; i >= 0; i--) begin
      si  = w[i];
      sen = 1'b1;
      tick();
    end
    sen = 1'b0;
    si  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_do_e"},   32'(ife.DO),   32'h0);
    chk({tag, "_dv_e"},   32'(ife.DV),   32'h0);
    chk({tag, "_perr_e"}, 32'(ife.PERR), 32'h0);
    chk({tag, "_ovf_e"},  32'(ife.OVF),  32'h0);
    chk({tag, "_ecnt_e"}, 32'(ife.ECNT), 32'h0);
    chk({tag, "_dv_o"},   32'(ifo.DV),   32'h0);
    chk({tag, "_ecnt_o"}, 32'(ifo.ECNT), 32'h0);
  endtask

  initial begin
    int exp_ecnt_e;
    int exp_ecnt_o;
    logic [21:0] two;

    n_cmp  = 0;
    n_fail = 0;
    rstn   = 1'b0;
    si     = 1'b0;
    sen    = 1'b0;
    clr    = 1'b0;
    drdy   = 1'b0;

    vecs[0] = '{11'h000, 1'b0, 1'b1};
    vecs[1] = '{11'h001, 1'b1, 1'b0};
    vecs[2] = '{11'h003, 1'b0, 1'b1};
    vecs[3] = '{11'h400, 1'b1, 1'b0};
    vecs[4] = '{11'h555, 1'b0, 1'b1};
    vecs[5] = '{11'h7FF, 1'b1, 1'b0};
    vecs[6] = '{11'h2AA, 1'b1, 1'b0};

    do_reset();
    chk_all_zero("reset");

    // 003 with consumer always ready: visible one cycle after 11th bit, drained next cycle
    drdy = 1'b1;
    shift_word(11'h003);
    chk("h003_dv",     32'(ife.DV),   32'h1);
    chk("h003_do",     32'(ife.DO),   32'h003);
    chk("h003_perr_e", 32'(ife.PERR), 32'h0);
    chk("h003_ecnt_e", 32'(ife.ECNT), 32'h0);
    chk("h003_perr_o", 32'(ifo.PERR), 32'h1);
    chk("h003_ecnt_o", 32'(ifo.ECNT), 32'h1);
    tick();
    chk("h003_drain_dv", 32'(ife.DV), 32'h0);

    do_reset();
    drdy = 1'b1;
    shift_word(11'h001);
    chk("h001_perr_e", 32'(ife.PERR), 32'h1);
    chk("h001_ecnt_e", 32'(ife.ECNT), 32'h1);
    chk("h001_perr_o", 32'(ifo.PERR), 32'h0);
    chk("h001_ecnt_o", 32'(ifo.ECNT), 32'h0);

    do_reset();
    exp_ecnt_e = 0;
    exp_ecnt_o = 0;
    for (int v = 0; v < 7; v++) begin
      drdy = 1'b0;
      shift_word(vecs[v].word);
      if (vecs[v].perr_even) exp_ecnt_e++;
      if (vecs[v].perr_odd)  exp_ecnt_o++;
      chk($sformatf("tbl%0d_dv", v),     32'(ife.DV),   32'h1);
      chk($sformatf("tbl%0d_do_e", v),   32'(ife.DO),   32'(vecs[v].word));
      chk($sformatf("tbl%0d_do_o", v),   32'(ifo.DO),   32'(vecs[v].word));
      chk($sformatf("tbl%0d_perr_e", v), 32'(ife.PERR), 32'(vecs[v].perr_even));
      chk($sformatf("tbl%0d_perr_o", v), 32'(ifo.PERR), 32'(vecs[v].perr_odd));
      chk($sformatf("tbl%0d_ecnt_e", v), 32'(ife.ECNT), 32'(exp_ecnt_e));
      chk($sformatf("tbl%0d_ecnt_o", v), 32'(ifo.ECNT), 32'(exp_ecnt_o));
      repeat (3) tick();
      chk($sformatf("tbl%0d_hold_do", v), 32'(ife.DO), 32'(vecs[v].word));
      drdy = 1'b1;
      tick();
      drdy = 1'b0;
      chk($sformatf("tbl%0d_drain_dv", v), 32'(ife.DV), 32'h0);
    end

    // overflow: second frame dropped while the first is held
    do_reset();
    shift_word(11'h003);
    chk("ovf_first_ovf", 32'(ife.OVF), 32'h0);
    shift_word(11'h7FF);
    chk("ovf_do",     32'(ife.DO),   32'h003);
    chk("ovf_perr",   32'(ife.PERR), 32'h0);
    chk("ovf_flag",   32'(ife.OVF),  32'h1);
    chk("ovf_ecnt_e", 32'(ife.ECNT), 32'h0);
    chk("ovf_ecnt_o", 32'(ifo.ECNT), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_clr_flag", 32'(ife.OVF), 32'h0);
    chk("ovf_clr_dv",   32'(ife.DV),  32'h1);
    chk("ovf_clr_do",   32'(ife.DO),  32'h003);

    // back-to-back frames, consumer ready only on the completing bit of frame two
    do_reset();
    two = {11'h123, 11'h456};
    for (int i = 21; i >= 0; i--) begin
      si   = two[i];
      sen  = 1'b1;
      drdy = (i == 0);
      tick();
      if (i == 11) begin
        chk("b2b_a_dv", 32'(ife.DV), 32'h1);
        chk("b2b_a_do", 32'(ife.DO), 32'h123);
      end
      if (i == 1) begin
        chk("b2b_mid_dv", 32'(ife.DV), 32'h1);
      end
    end
    sen  = 1'b0;
    drdy = 1'b0;
    chk("b2b_b_dv",   32'(ife.DV),   32'h1);
    chk("b2b_b_do",   32'(ife.DO),   32'h456);
    chk("b2b_b_perr", 32'(ife.PERR), 32'h1);
    chk("b2b_b_ecnt", 32'(ife.ECNT), 32'h1);
    chk("b2b_b_ovf",  32'(ife.OVF),  32'h0);

    // asynchronous reset mid-frame, then a clean frame
    do_reset();
    shift_word(11'h7FF);
    for (int i = 0; i < 5; i++) begin
      si  = 1'b1;
      sen = 1'b1;
      tick();
    end
    rstn = 1'b0;
    #2;
    chk_all_zero("async_rst");
    sen = 1'b0;
    tick();
    rstn = 1'b1;
    shift_word(11'h555);
    chk("post_rst_dv",   32'(ife.DV),   32'h1);
    chk("post_rst_do",   32'(ife.DO),   32'h555);
    chk("post_rst_perr", 32'(ife.PERR), 32'h0);

    // CLR wins over SEN and restarts the partial frame
    do_reset();
    for (int i = 0; i < 5; i++) begin
      si  = 1'b1;
      sen = 1'b1;
      tick();
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    sen = 1'b0;
    repeat (2) tick();
    shift_word(11'h0F0);
    chk("clr_restart_dv", 32'(ife.DV), 32'h1);
    chk("clr_restart_do", 32'(ife.DO), 32'h0F0);
    clr  = 1'b1;
    drdy = 1'b1;
    tick();
    clr  = 1'b0;
    drdy = 1'b0;
    chk("clr_drain_dv", 32'(ife.DV), 32'h0);
    chk("clr_drain_do", 32'(ife.DO), 32'h0F0);

    // error counter saturation
    do_reset();
    drdy = 1'b1;
    for (int f = 0; f < 260; f++) begin
      shift_word(11'h001);
      if (f == 253) chk("sat_254", 32'(ife.ECNT), 32'd254);
      if (f == 254) chk("sat_255", 32'(ife.ECNT), 32'd255);
    end
    chk("sat_hold_e", 32'(ife.ECNT), 32'd255);
    chk("sat_odd",    32'(ifo.ECNT), 32'd0);
    drdy = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_word_checker.md
PARITY_WORD_CHECKER -- requirements
Module: parity_word_checker

Interface
REQ-001 SHALL have parameter PARITY_ODD, default 0; 0 = even parity (valid frame when XOR of all 11 bits = 0), 1 = odd parity (valid frame when XOR = 1).
REQ-002 SHALL have port CK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RSTN  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port SI  input  1  serial frame bit, MSB first.
REQ-005 SHALL have port SEN  input  1  shift enable; SI is sampled when high.
REQ-006 SHALL have port CLR  input  1  synchronous frame restart.
REQ-007 SHALL have port DRDY  input  1  consumer ready for DO.
REQ-008 SHALL have port DO  output  11  assembled frame, bit 10 = first bit received.
REQ-009 SHALL have port DV  output  1  DO/PERR valid.
REQ-010 SHALL have port PERR  output  1  parity error flag for the presented frame.
REQ-011 SHALL have port OVF  output  1  sticky flag: a frame was dropped.
REQ-012 SHALL have port ECNT  output  8  saturating count of accepted frames with PERR=1.

Function
REQ-013 SHALL keep an 11-bit shift register and a 4-bit bit counter (0..10); on SEN=1, SR <= {SR[9:0],SI} and the counter increments.
REQ-014 SHALL complete a frame on the cycle with SEN=1 and counter=10; the counter then wraps to 0 in the same edge.
REQ-015 SHALL compute frame parity as the XOR reduction of all 11 completed bits, {SR[9:0],SI}; PERR = XOR for PARITY_ODD=0 and ~XOR for PARITY_ODD=1.
REQ-016 SHALL implement a one-entry output holding register with states EMPTY (DV=0) and FULL (DV=1).
REQ-017 SHALL accept a completed frame when EMPTY, or when FULL with DV&DRDY in the same cycle: load DO and PERR, DV=1 on the next cycle; latency = 1 cycle after the 11th SEN.
REQ-018 SHALL transition FULL->EMPTY on DV&DRDY when no frame completes in that cycle.
REQ-019 SHALL drop a completed frame when FULL and DRDY=0: DO, PERR and ECNT are unchanged, and OVF is set to 1.
REQ-020 SHALL hold DO and PERR stable while DV=1 and DRDY=0.
REQ-021 SHALL increment ECNT by 1 for each accepted frame with PERR=1, saturating at 255; dropped frames are not counted.
REQ-022 SHALL, on CLR=1, zero SR and the counter, discard any SI bit sampled in that cycle (CLR wins over SEN), and clear OVF; DO, DV, PERR and ECNT are unaffected.
REQ-023 SHALL, when CLR=1 and DV&DRDY occur together, still perform the drain (FULL->EMPTY).
REQ-024 SHALL ignore SI when SEN=0; the counter and SR hold.

Reset
REQ-025 SHALL, while RSTN=0, asynchronously force SR=0, counter=0, DO=0, DV=0, PERR=0, OVF=0 and ECNT=0.
REQ-026 SHALL start the first frame after RSTN deasserts with the first SEN=1 cycle; a partial frame in progress at reset is discarded.

Verification
REQ-027 SHALL cover: PARITY_ODD=0, shift 11'h003 with DRDY=1 -> DV=1 one cycle after the 11th bit, DO=11'h003, PERR=0, ECNT=0.
REQ-028 SHALL cover: PARITY_ODD=0, shift 11'h001 -> PERR=1 and ECNT=1; the same stimulus with PARITY_ODD=1 -> PERR=0 and ECNT=0.
REQ-029 SHALL cover: DRDY=0, shift 11'h003 then 11'h7FF -> DO remains 11'h003, OVF=1 after the second frame, ECNT=0; a following CLR pulse -> OVF=0.
REQ-030 SHALL cover: 22 continuous SEN cycles with DRDY=1 at the second frame's completion -> DV stays 1 across the handover and DO updates to the second frame with no gap.
REQ-031 SHALL cover: RSTN pulsed low after 5 bits of a frame -> all outputs 0; the next 11 bits 11'h555 give DO=11'h555 and PERR=0.
REQ-032 SHALL cover: 260 accepted error frames -> ECNT=255 and held there.
